// File: rtl/uart_bank_scheduler.sv
// UART frame bank scheduler: buffers received 256-bit frames and writes
// them word by word into a shared frame RAM, sharing the port with reads.
module uart_bank_scheduler #(
  parameter int NUM_BANKS = 8,
  parameter int BANK_AW   = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [255:0]       FRAME_DATA,
  input  logic               FRAME_STROBE,
  input  logic [7:0]         FRAME_BANK,
  input  logic               RD_REQ,
  input  logic [BANK_AW-1:0] RD_BANK,
  input  logic [2:0]         RD_WORD,
  output logic               RD_GNT,
  output logic               RD_VALID,
  output logic [31:0]        RD_DATA,
  output logic               MEM_WE,
  output logic               MEM_RE,
  output logic [BANK_AW+2:0] MEM_ADDR,
  output logic [31:0]        MEM_WDATA,
  input  logic [31:0]        MEM_RDATA,
  output logic               WR_DONE,
  output logic [7:0]         WR_BANK_LAST,
  output logic               BANK_ERR,
  output logic [7:0]         DROP_CNT,
  output logic               BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  localparam logic [8:0] NB = 9'(NUM_BANKS);

  state_t state, state_nxt;

  logic               pend_v;
  logic [255:0]       pend_data;
  logic [BANK_AW-1:0] pend_bank;
  logic [255:0]       act_data;
  logic [BANK_AW-1:0] act_bank;
  logic [2:0]         wptr, wptr_nxt;
  logic               prio_rd;

  logic               xfer;
  logic               wr_req;
  logic               rd_req;
  logic               rd_win;
  logic               wr_win;
  logic [2:0]         wr_idx;
  logic [BANK_AW-1:0] wr_bank;
  logic [31:0]        wr_word;
  logic               bank_ok;
  logic               accept;
  logic               drop;

  // Word 0 is issued straight from pending in the cycle it moves to active.
  assign xfer    = (state == IDLE) && pend_v;
  assign wr_req  = xfer || (state == WRITE);
  assign rd_req  = RD_REQ && !RD_GNT;
  assign rd_win  = rd_req && (!wr_req || prio_rd);
  assign wr_win  = wr_req && !rd_win;
  assign wr_idx  = xfer ? 3'd0 : wptr;
  assign wr_bank = xfer ? pend_bank : act_bank;
  assign wr_word = xfer ? pend_data[31:0]
                        : act_data[{wptr, 5'd0} +: 32];

  assign bank_ok = {1'b0, FRAME_BANK} < NB;
  assign accept  = FRAME_STROBE && bank_ok && (!pend_v || xfer);
  assign drop    = FRAME_STROBE && bank_ok && !accept;

  assign BUSY    = pend_v || (state != IDLE);
  assign RD_DATA = RD_VALID ? MEM_RDATA : 32'd0;

  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    unique case (state)
      IDLE: begin
        if (pend_v) begin
          state_nxt = WRITE;
          wptr_nxt  = wr_win ? 3'd1 : 3'd0;
        end
      end
      WRITE: begin
        if (wr_win) begin
          wptr_nxt = wptr + 3'd1;
          if (wptr == 3'd7) state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      wptr  <= '0;
    end else begin
      state <= state_nxt;
      wptr  <= wptr_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_v    <= 1'b0;
      pend_data <= '0;
      pend_bank <= '0;
      act_data  <= '0;
      act_bank  <= '0;
    end else begin
      if (xfer) begin
        pend_v   <= 1'b0;
        act_data <= pend_data;
        act_bank <= pend_bank;
      end
      if (accept) begin
        pend_v    <= 1'b1;
        pend_data <= FRAME_DATA;
        pend_bank <= FRAME_BANK[BANK_AW-1:0];
      end
    end
  end

  // Round-robin: the loser of a contended cycle wins the next one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prio_rd   <= 1'b1;
      MEM_WE    <= 1'b0;
      MEM_RE    <= 1'b0;
      RD_GNT    <= 1'b0;
      RD_VALID  <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
    end else begin
      if (rd_req && wr_req) prio_rd <= !rd_win;
      MEM_WE   <= wr_win;
      MEM_RE   <= rd_win;
      RD_GNT   <= rd_win;
      RD_VALID <= MEM_RE;
      if (rd_win)
        MEM_ADDR <= {RD_BANK, RD_WORD};
      else if (wr_win)
        MEM_ADDR <= {wr_bank, wr_idx};
      else
        MEM_ADDR <= '0;
      MEM_WDATA <= wr_win ? wr_word : 32'd0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WR_DONE      <= 1'b0;
      WR_BANK_LAST <= '0;
      BANK_ERR     <= 1'b0;
      DROP_CNT     <= '0;
    end else begin
      WR_DONE  <= (state == DONE);
      BANK_ERR <= FRAME_STROBE && !bank_ok;
      if (state == DONE) WR_BANK_LAST <= 8'(act_bank);
      if (drop && DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
    end
  end

endmodule
